// File: rtl/chip.sv
// Two-player tic-tac-toe engine: registered 3x3 board, turn/result FSM and winner flag.
// Every output is a register; moves are judged against the post-move board at the same edge.
module chip (
    input  logic        ph2,
    input  logic        reset,
    input  logic        isPlayer1Start,
    input  logic        playerWrite,
    input  logic [3:0]  playerInput,
    output logic [17:0] gBoard,
    output logic [2:0]  gameState,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {
        P1_TURN = 3'b001,
        P2_TURN = 3'b010,
        P1_WIN  = 3'b011,
        P2_WIN  = 3'b100,
        DRAW    = 3'b101
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [17:0] r_board;
    logic [17:0] w_nextBoard;
    logic [1:0]  r_winner;
    logic [1:0]  w_nextWinner;

    logic [1:0]  w_moverCode;
    logic [31:0] w_boardPad;
    logic [1:0]  w_target;
    logic        w_moveOk;
    logic [17:0] w_placed;
    logic        w_full;

    function automatic logic cellIs(input logic [17:0] b, input int idx, input logic [1:0] code);
        return b[2*idx +: 2] == code;
    endfunction

    function automatic logic hasLine(input logic [17:0] b, input logic [1:0] code);
        return (cellIs(b, 0, code) && cellIs(b, 1, code) && cellIs(b, 2, code)) ||
               (cellIs(b, 3, code) && cellIs(b, 4, code) && cellIs(b, 5, code)) ||
               (cellIs(b, 6, code) && cellIs(b, 7, code) && cellIs(b, 8, code)) ||
               (cellIs(b, 0, code) && cellIs(b, 3, code) && cellIs(b, 6, code)) ||
               (cellIs(b, 1, code) && cellIs(b, 4, code) && cellIs(b, 7, code)) ||
               (cellIs(b, 2, code) && cellIs(b, 5, code) && cellIs(b, 8, code)) ||
               (cellIs(b, 0, code) && cellIs(b, 4, code) && cellIs(b, 8, code)) ||
               (cellIs(b, 2, code) && cellIs(b, 4, code) && cellIs(b, 6, code));
    endfunction

    always_ff @(posedge ph2) begin
        if (!reset) begin
            r_board  <= 18'b0;
            r_winner <= 2'b11;
            r_state  <= isPlayer1Start ? P1_TURN : P2_TURN;
        end else begin
            r_board  <= w_nextBoard;
            r_winner <= w_nextWinner;
            r_state  <= w_nextState;
        end
    end

    // Indices 9..15 land in the padding, which reads as occupied and so is never writable.
    always_comb begin
        w_moverCode = (r_state == P1_TURN) ? 2'b01 : 2'b10;
        w_boardPad  = {14'h3FFF, r_board};
        w_target    = w_boardPad[{playerInput, 1'b0} +: 2];
        w_moveOk    = playerWrite && (playerInput <= 4'd8) && (w_target == 2'b00) &&
                      ((r_state == P1_TURN) || (r_state == P2_TURN));
        w_placed    = r_board | (18'(w_moverCode) << {playerInput, 1'b0});
        w_full      = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (w_placed[2*i +: 2] == 2'b00) w_full = 1'b0;
        end

        w_nextBoard  = r_board;
        w_nextWinner = r_winner;
        w_nextState  = r_state;

        case (r_state)
            P1_TURN, P2_TURN: begin
                if (w_moveOk) begin
                    w_nextBoard = w_placed;
                    if (hasLine(w_placed, w_moverCode)) begin
                        w_nextState  = (r_state == P1_TURN) ? P1_WIN : P2_WIN;
                        w_nextWinner = w_moverCode;
                    end else if (w_full) begin
                        w_nextState  = DRAW;
                        w_nextWinner = 2'b00;
                    end else begin
                        w_nextState = (r_state == P1_TURN) ? P2_TURN : P1_TURN;
                    end
                end
            end
            P1_WIN, P2_WIN, DRAW: ;
            // Corrupted state code: restart a fresh game rather than stay stuck.
            default: begin
                w_nextBoard  = 18'b0;
                w_nextWinner = 2'b11;
                w_nextState  = P1_TURN;
            end
        endcase
    end

    assign gBoard    = r_board;
    assign gameState = r_state;
    assign winner    = r_winner;

endmodule

// File: tb/tb_chip.sv
// Directed self-checking bench for chip: each step pushes its expected outcome to a
// scoreboard queue, which is popped and compared after the next rising edge.
module tb_chip;

    logic        ph2;
    logic        reset;
    logic        isPlayer1Start;
    logic        playerWrite;
    logic [3:0]  playerInput;
    logic [17:0] gBoard;
    logic [2:0]  gameState;
    logic [1:0]  winner;

    typedef struct {
        logic [17:0] board;
        logic [2:0]  state;
        logic [1:0]  win;
        string       tag;
    } exp_t;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [17:0] eb;
    logic [2:0]  es;
    logic [1:0]  ew;
    logic        p1s;

    chip dut (
        .ph2           (ph2),
        .reset         (reset),
        .isPlayer1Start(isPlayer1Start),
        .playerWrite   (playerWrite),
        .playerInput   (playerInput),
        .gBoard        (gBoard),
        .gameState     (gameState),
        .winner        (winner)
    );

    initial ph2 = 1'b0;
    always #5 ph2 = ~ph2;

    function automatic logic [17:0] setCell(input logic [17:0] b, input int idx, input logic [1:0] v);
        logic [17:0] r;
        r = b;
        r[2*idx +: 2] = v;
        return r;
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = expQ.pop_front();
        checks += 3;
        assert (gBoard === e.board) else begin
            failures++;
            $error("[TB] FAIL %s.board observed=%b expected=%b", e.tag, gBoard, e.board);
        end
        assert (gameState === e.state) else begin
            failures++;
            $error("[TB] FAIL %s.state observed=%b expected=%b", e.tag, gameState, e.state);
        end
        assert (winner === e.win) else begin
            failures++;
            $error("[TB] FAIL %s.winner observed=%b expected=%b", e.tag, winner, e.win);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic wr, input logic [3:0] idx, input string tag);
        exp_t e;
        reset          = rst;
        isPlayer1Start = p1s;
        playerWrite    = wr;
        playerInput    = idx;
        e.board = eb;
        e.state = es;
        e.win   = ew;
        e.tag   = tag;
        expQ.push_back(e);
        @(posedge ph2);
        #1;
        checkOutput();
    endtask

    // Reset step (optionally with a simultaneous write that must be dropped).
    task automatic doReset(input logic start1, input logic wr, input logic [3:0] idx, input string tag);
        p1s = start1;
        eb  = 18'b0;
        es  = start1 ? 3'b001 : 3'b010;
        ew  = 2'b11;
        applyStimulus(1'b0, wr, idx, tag);
    endtask

    // Accepted move by whoever holds the turn in the expected model.
    task automatic mv(input int idx, input logic [2:0] nextS, input logic [1:0] nextW, input string tag);
        eb = setCell(eb, idx, (es == 3'b001) ? 2'b01 : 2'b10);
        es = nextS;
        ew = nextW;
        applyStimulus(1'b1, 1'b1, 4'(idx), tag);
    endtask

    task automatic rej(input logic [3:0] idx, input string tag);
        applyStimulus(1'b1, 1'b1, idx, tag);
    endtask

    initial begin
        p1s = 1'b0;
        eb = '0; es = 3'b010; ew = 2'b11;
        reset = 1'b0; isPlayer1Start = 1'b0; playerWrite = 1'b0; playerInput = 4'd0;

        doReset(1'b0, 1'b0, 4'd0, "rst_p2_a");
        doReset(1'b0, 1'b0, 4'd0, "rst_p2_b");
        applyStimulus(1'b1, 1'b0, 4'd0, "idle");
        applyStimulus(1'b1, 1'b0, 4'd0, "idle2");

        mv(4, 3'b001, 2'b11, "w4_p2");
        mv(0, 3'b010, 2'b11, "w0_p1");
        rej(4'd4, "rep4");
        mv(1, 3'b001, 2'b11, "w1_p2");
        rej(4'd12, "idx12");
        rej(4'd9, "idx9");
        rej(4'd15, "idx15");

        doReset(1'b1, 1'b1, 4'd2, "rst_with_write");
        mv(0, 3'b010, 2'b11, "g1_0");
        mv(3, 3'b001, 2'b11, "g1_3");
        mv(1, 3'b010, 2'b11, "g1_1");
        mv(4, 3'b001, 2'b11, "g1_4");
        mv(2, 3'b011, 2'b01, "g1_win");
        rej(4'd8, "after_win_a");
        rej(4'd8, "after_win_b");

        doReset(1'b0, 1'b0, 4'd0, "rst_g2");
        mv(0, 3'b001, 2'b11, "g2_0");
        mv(3, 3'b010, 2'b11, "g2_3");
        mv(1, 3'b001, 2'b11, "g2_1");
        mv(4, 3'b010, 2'b11, "g2_4");
        mv(2, 3'b100, 2'b10, "g2_p2win");
        rej(4'd8, "after_p2win");
        doReset(1'b1, 1'b1, 4'd8, "rst_from_p2win");

        mv(0, 3'b010, 2'b11, "d_0");
        mv(1, 3'b001, 2'b11, "d_1");
        p1s = 1'b0;
        mv(2, 3'b010, 2'b11, "d_2_p1s_toggled");
        mv(4, 3'b001, 2'b11, "d_4");
        p1s = 1'b1;
        mv(3, 3'b010, 2'b11, "d_3");
        mv(5, 3'b001, 2'b11, "d_5");
        mv(7, 3'b010, 2'b11, "d_7");
        mv(6, 3'b001, 2'b11, "d_6");
        mv(8, 3'b101, 2'b00, "d_draw");
        rej(4'd0, "after_draw");

        doReset(1'b1, 1'b0, 4'd0, "rst_g4");
        mv(0, 3'b010, 2'b11, "n_0");
        mv(3, 3'b001, 2'b11, "n_3");
        mv(1, 3'b010, 2'b11, "n_1");
        mv(4, 3'b001, 2'b11, "n_4");
        mv(5, 3'b010, 2'b11, "n_5");
        mv(7, 3'b001, 2'b11, "n_7");
        mv(6, 3'b010, 2'b11, "n_6");
        mv(8, 3'b001, 2'b11, "n_8");
        mv(2, 3'b011, 2'b01, "n_ninth_win");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
